// File: rtl/div_if.sv
// ---------------------------------------------------------------------------
// div_if -- operand / result bundle between the execute stage and the divider
//
// Signals
//   signed_div_i  1   1 = two's-complement division, 0 = unsigned
//   opdata1_i     32  dividend
//   opdata2_i     32  divisor
//   start_i       1   request, held high until ready_o is seen
//   annul_i       1   abort the current operation (only with DIV_ANNUL_EN)
//   result_o      64  {remainder, quotient}
//   ready_o       1   result_o valid
//
// Modports
//   master  execute stage side (drives operands and request)
//   slave   divider side (drives result and ready)
//
// Build option: DIV_ANNUL_EN adds the annul_i signal.
// ---------------------------------------------------------------------------
interface div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
`ifdef DIV_ANNUL_EN
  logic        annul_i;
`endif
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    output start_i,
`ifdef DIV_ANNUL_EN
    output annul_i,
`endif
    input  result_o,
    input  ready_o
  );

  modport slave (
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    input  start_i,
`ifdef DIV_ANNUL_EN
    input  annul_i,
`endif
    output result_o,
    output ready_o
  );
endinterface

// File: rtl/div.sv
// ---------------------------------------------------------------------------
// div -- 32-bit multi-cycle divider (restoring shift-subtract)
//
// One quotient bit per cycle, MSB first; a request is accepted from FREE and
// the result appears 32 cycles later (or one cycle later for a zero divisor,
// which returns 0). The result is held while start_i stays high and cleared
// when the requester drops start_i.
//
// Ports
//   clk   rising-edge clock for all state
//   rst   synchronous active-low reset
//   bus   div_if.slave: operands, start/annul request, result/ready
//
// Build option: DIV_ANNUL_EN enables annul_i (abort from ON/BYZERO, and
// blocks acceptance in FREE). Without it every operation runs to END.
// ---------------------------------------------------------------------------
module div (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t      r_state,    w_state_nxt;
  logic [4:0]  r_cnt,      w_cnt_nxt;
  logic [31:0] r_dividend, w_dividend_nxt;  // shifts out dividend, shifts in quotient
  logic [31:0] r_divisor,  w_divisor_nxt;
  logic [31:0] r_rem,      w_rem_nxt;
  logic        r_neg_q,    w_neg_q_nxt;
  logic        r_neg_r,    w_neg_r_nxt;
  logic [63:0] r_result,   w_result_nxt;
  logic        r_ready,    w_ready_nxt;

  logic        w_annul;
  logic        w_op1_neg;
  logic        w_op2_neg;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic [32:0] w_partial;
  logic [32:0] w_diff;
  logic        w_fits;
  logic [31:0] w_q_step;
  logic [31:0] w_rem_step;

`ifdef DIV_ANNUL_EN
  assign w_annul = bus.annul_i;
`else
  assign w_annul = 1'b0;
`endif

  // Operand magnitudes, only meaningful on the acceptance edge.
  assign w_op1_neg = bus.signed_div_i & bus.opdata1_i[31];
  assign w_op2_neg = bus.signed_div_i & bus.opdata2_i[31];
  assign w_mag1    = w_op1_neg ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
  assign w_mag2    = w_op2_neg ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;

  // One restoring step. The partial remainder is always below 2*divisor, so
  // bit 32 of the 33-bit difference is set exactly when the subtract borrows.
  assign w_partial  = {r_rem, r_dividend[31]};
  assign w_diff     = w_partial - {1'b0, r_divisor};
  assign w_fits     = ~w_diff[32];
  assign w_q_step   = {r_dividend[30:0], w_fits};
  assign w_rem_step = w_fits ? w_diff[31:0] : w_partial[31:0];

  always_comb begin
    // NOTE: every next-state value gets a hold default first so no path
    // through the case leaves a variable unassigned (which would infer a latch).
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_dividend_nxt = r_dividend;
    w_divisor_nxt  = r_divisor;
    w_rem_nxt      = r_rem;
    w_neg_q_nxt    = r_neg_q;
    w_neg_r_nxt    = r_neg_r;
    w_result_nxt   = r_result;
    w_ready_nxt    = r_ready;

    unique case (r_state)
      FREE: begin
        w_result_nxt = 64'd0;
        w_ready_nxt  = 1'b0;
        if (bus.start_i && !w_annul) begin
          if (bus.opdata2_i == 32'd0) begin
            w_state_nxt = BYZERO;
          end else begin
            w_state_nxt    = ON;
            w_cnt_nxt      = 5'd0;
            w_dividend_nxt = w_mag1;
            w_divisor_nxt  = w_mag2;
            w_rem_nxt      = 32'd0;
            // Sign mode is latched here so later input changes are ignored.
            w_neg_q_nxt    = w_op1_neg ^ w_op2_neg;
            w_neg_r_nxt    = w_op1_neg;
          end
        end
      end

      BYZERO: begin
        w_result_nxt = 64'd0;
        if (w_annul) begin
          w_state_nxt = FREE;
          w_ready_nxt = 1'b0;
        end else begin
          w_state_nxt = END;
          w_ready_nxt = 1'b1;
        end
      end

      ON: begin
        if (w_annul) begin
          w_state_nxt  = FREE;
          w_ready_nxt  = 1'b0;
          w_result_nxt = 64'd0;
        end else begin
          w_dividend_nxt = w_q_step;
          w_rem_nxt      = w_rem_step;
          w_cnt_nxt      = r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            w_state_nxt  = END;
            w_ready_nxt  = 1'b1;
            w_result_nxt = {(r_neg_r ? (~w_rem_step + 32'd1) : w_rem_step),
                            (r_neg_q ? (~w_q_step   + 32'd1) : w_q_step)};
          end
        end
      end

      END: begin
        if (!bus.start_i) begin
          w_state_nxt  = FREE;
          w_ready_nxt  = 1'b0;
          w_result_nxt = 64'd0;
        end
      end

      default: begin
        w_state_nxt  = FREE;
        w_ready_nxt  = 1'b0;
        w_result_nxt = 64'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the datapath registers are reset too, not just the control
      // state, so an aborted operation leaves no stale operands behind.
      r_state    <= FREE;
      r_cnt      <= 5'd0;
      r_dividend <= 32'd0;
      r_divisor  <= 32'd0;
      r_rem      <= 32'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_result   <= 64'd0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dividend <= w_dividend_nxt;
      r_divisor  <= w_divisor_nxt;
      r_rem      <= w_rem_nxt;
      r_neg_q    <= w_neg_q_nxt;
      r_neg_r    <= w_neg_r_nxt;
      r_result   <= w_result_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;

endmodule
